pixel_scanner: RTL

Frame-level pixel sequencer at the head of the ray-marching pipeline. It raster-scans a `H_RES`×`V_RES` screen and emits one pixel coordinate per accepted transfer as Q11.21 `screen_x`/`screen_y`, the format the ray generator consumes. At frame start it snapshots the camera basis, so every pixel of a frame uses one consistent basis even when software updates the camera mid-frame. Downstream backpressure is honoured through a valid/ready handshake.

---
 rtl/pixel_scanner_if.sv | 32 +++
 rtl/pixel_scanner.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pixel_scanner_if.sv
// pixel_scanner_if -- pixel stream and camera-basis bundle for pixel_scanner.
// vec3 values are packed [2:0][31:0] with [0]=x, [1]=y, [2]=z.
// master: the scanner itself; slave: the downstream consumer / register file side.
interface pixel_scanner_if;
  logic             start;
  logic [2:0][31:0] cam_forward_in;
  logic [2:0][31:0] cam_right_in;
  logic [2:0][31:0] cam_up_in;
  logic [2:0][31:0] camera_forward;
  logic [2:0][31:0] camera_right;
  logic [2:0][31:0] camera_up;
  logic [31:0]      screen_x;
  logic [31:0]      screen_y;
  logic             valid_out;
  logic             ready_in;
  logic             sof;
  logic             eol;
  logic             busy;
  logic             frame_done;

  modport master (
    input  start, cam_forward_in, cam_right_in, cam_up_in, ready_in,
    output camera_forward, camera_right, camera_up,
    output screen_x, screen_y, valid_out, sof, eol, busy, frame_done
  );

  modport slave (
    output start, cam_forward_in, cam_right_in, cam_up_in, ready_in,
    input  camera_forward, camera_right, camera_up,
    input  screen_x, screen_y, valid_out, sof, eol, busy, frame_done
  );
endinterface

// File: rtl/pixel_scanner.sv
// pixel_scanner -- raster-scans an H_RES x V_RES screen, one Q11.21 pixel
// coordinate per valid/ready transfer, with a per-frame snapshot of the camera basis.
// Optional feature: define PIXEL_SCAN_CONTINUOUS_EN to chain frames back to back
// while start is held high (start then acts as a run-enable level).
module pixel_scanner #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  pixel_scanner_if.master   scan_if
);

  // A 1-pixel dimension still needs a 1-bit counter so the ports stay well formed.
  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             run_q, done_q;
  logic             latch_cam;
  logic             xfer;
  logic [2:0][31:0] fwd_q, right_q, up_q;

  assign xfer = run_q && scan_if.ready_in;

  // Next-state, counter advance and camera-latch decision.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    latch_cam = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_if.start) begin
          state_d   = S_RUN;
          col_d     = '0;
          row_d     = '0;
          latch_cam = 1'b1;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DONE: begin
`ifdef PIXEL_SCAN_CONTINUOUS_EN
        if (scan_if.start) begin
          state_d   = S_RUN;
          col_d     = '0;
          row_d     = '0;
          latch_cam = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered status flags.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      run_q   <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Per-frame camera basis snapshot; only the frame-start event updates it.
  // NOTE: these data registers are reset because their cleared value is visible on the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q   <= '0;
      right_q <= '0;
      up_q    <= '0;
    end else if (latch_cam) begin
      fwd_q   <= scan_if.cam_forward_in;
      right_q <= scan_if.cam_right_in;
      up_q    <= scan_if.cam_up_in;
    end
  end

  // Coordinates are the counters placed in the Q11.21 integer field.
  assign scan_if.screen_x       = {11'(col_q), 21'd0};
  assign scan_if.screen_y       = {11'(row_q), 21'd0};
  assign scan_if.valid_out      = run_q;
  assign scan_if.busy           = run_q;
  assign scan_if.frame_done     = done_q;
  assign scan_if.sof            = run_q && (col_q == '0) && (row_q == '0);
  assign scan_if.eol            = run_q && (col_q == COL_LAST);
  assign scan_if.camera_forward = fwd_q;
  assign scan_if.camera_right   = right_q;
  assign scan_if.camera_up      = up_q;

endmodule
